// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Purpose  : Set-associative, read-only instruction cache. Lookups are
//            combinational (hit returns the instruction in the same cycle).
//            A miss stalls fetch, reads one whole line over the bus and
//            installs it into a victim way chosen by lowest invalid way or,
//            failing that, a per-set tree pseudo-LRU. A flush invalidates
//            every set, one set per cycle.
// Ports    : clk      - clock, all state updates on rising edge
//            clr_n    - asynchronous active-low reset
//            pc       - fetch address (pc[1:0] ignored)
//            pc_rd    - fetch request valid
//            ir       - instruction, 0 whenever ir_vld=0
//            ir_vld   - hit, ir valid this cycle
//            stall    - pc_rd & ~ir_vld
//            flush    - single-cycle pulse, invalidate all lines
//            b_addr   - line-aligned miss address (0 outside a request)
//            b_rd     - bus line-read request
//            b_dv     - bus data valid
//            b_data   - returned line, little-endian bytes
//            hit_cnt  - hit counter   (only with ICACHE_PERF_EN)
//            miss_cnt - miss counter  (only with ICACHE_PERF_EN)
// Config   : define ICACHE_PERF_EN to add the hit/miss performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module icache #(
  parameter int LINE_BITS = 1024,
  parameter int SETS      = 4,
  parameter int WAYS      = 4
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [63:0]          pc,
  input  logic                 pc_rd,
  output logic [31:0]          ir,
  output logic                 ir_vld,
  output logic                 stall,
  input  logic                 flush,
  output logic [63:0]          b_addr,
  output logic                 b_rd,
  input  logic                 b_dv,
  input  logic [LINE_BITS-1:0] b_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [63:0]          hit_cnt,
  output logic [63:0]          miss_cnt
`endif
);

  localparam int OFFS_W = $clog2(LINE_BITS / 8);
  localparam int SET_W  = $clog2(SETS);
  localparam int TAG_W  = 64 - SET_W - OFFS_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int PW     = WAYS - 1;   // PLRU tree bits per set

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Storage
  logic [LINE_BITS-1:0] r_data [SETS][WAYS];
  logic [TAG_W-1:0]     r_tag  [SETS][WAYS];
  logic [WAYS-1:0]      r_v    [SETS];
  logic [PW-1:0]        r_plru [SETS];

  // Miss latch and flush bookkeeping
  logic [TAG_W-1:0] r_miss_tag;
  logic [SET_W-1:0] r_miss_set;
  logic             r_flush_pend;
  logic [SET_W-1:0] r_flush_set;

  // Lookup
  logic [TAG_W-1:0]     w_tag;
  logic [SET_W-1:0]     w_set;
  logic [WAYS-1:0]      w_hitv;
  logic                 w_hit;
  logic [WAY_W-1:0]     w_hit_way;
  logic [LINE_BITS-1:0] w_line;
  logic [31:0]          w_word;

  // Control strobes from the FSM
  logic w_miss_start;
  logic w_fill;
  logic w_flush_start;

  // Victim selection and PLRU update
  logic [WAYS-1:0]  w_vset;
  logic             w_inv_any;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_plru_way;
  logic [WAY_W-1:0] w_victim;
  logic             w_upd_en;
  logic [SET_W-1:0] w_upd_set;
  logic [WAY_W-1:0] w_upd_way;
  logic [PW-1:0]    w_plru_nxt;

  logic w_unused_pc;
  assign w_unused_pc = &{1'b0, pc[1:0]};

  // --------------------------------------------------------------------------
  // Tag compare
  // --------------------------------------------------------------------------
  assign w_tag = pc[63:SET_W+OFFS_W];
  assign w_set = pc[SET_W+OFFS_W-1:OFFS_W];

  for (genvar g = 0; g < WAYS; g++) begin : g_way_cmp
    assign w_hitv[g] = r_v[w_set][g] && (r_tag[w_set][g] == w_tag);
  end

  assign w_hit = |w_hitv;

  always_comb begin
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_hitv[w]) w_hit_way = WAY_W'(w);
    end
  end

  // Word select: the offset is forced to a word boundary, so a fetch never
  // straddles two lines.
  assign w_line = r_data[w_set][w_hit_way];
  assign w_word = w_line[{pc[OFFS_W-1:2], 5'b00000} +: 32];

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    ir_vld        = 1'b0;
    b_rd          = 1'b0;
    b_addr        = '0;
    w_miss_start  = 1'b0;
    w_fill        = 1'b0;
    w_flush_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ir_vld = pc_rd & w_hit;
        // Flush wins over a simultaneous miss.
        if (flush || r_flush_pend) begin
          w_state_nxt   = ST_FLUSH;
          w_flush_start = 1'b1;
        end else if (pc_rd && !w_hit) begin
          w_state_nxt  = ST_REQ;
          w_miss_start = 1'b1;
        end
      end
      ST_REQ: begin
        b_rd   = 1'b1;
        b_addr = {r_miss_tag, r_miss_set, {OFFS_W{1'b0}}};
        if (b_dv) begin
          w_fill      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (r_flush_set == SET_W'(SETS - 1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ir    = ir_vld ? w_word : 32'h0;
  assign stall = pc_rd & ~ir_vld;

  // --------------------------------------------------------------------------
  // Victim: lowest-index invalid way, else walk the PLRU tree from the root.
  // Tree nodes are heap-ordered: children of node n are 2n+1 (lower half)
  // and 2n+2 (upper half).
  // --------------------------------------------------------------------------
  assign w_vset = r_v[r_miss_set];

  always_comb begin
    w_inv_any = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_vset[w]) begin
        w_inv_any = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  always_comb begin : plru_walk
    int            node;
    logic [PW-1:0] t;
    node       = 0;
    t          = '0;
    w_plru_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      t          = r_plru[r_miss_set] >> node;
      w_plru_way = (w_plru_way << 1) | WAY_W'(t[0]);
      node       = 2 * node + 1 + int'(t[0]);
    end
  end

  assign w_victim = w_inv_any ? w_inv_way : w_plru_way;

  // Hits and fills never coincide (hits only in IDLE, fills only in REQ).
  assign w_upd_en  = ir_vld | w_fill;
  assign w_upd_set = w_fill ? r_miss_set : w_set;
  assign w_upd_way = w_fill ? w_victim : w_hit_way;

  // Every node on the accessed way's path is turned to point away from it.
  always_comb begin : plru_touch
    int               node;
    logic [WAY_W-1:0] sh;
    logic             d;
    logic             nd;
    node       = 0;
    sh         = '0;
    d          = 1'b0;
    nd         = 1'b0;
    w_plru_nxt = r_plru[w_upd_set];
    for (int l = 0; l < WAY_W; l++) begin
      sh         = w_upd_way >> (WAY_W - 1 - l);
      d          = sh[0];
      nd         = ~d;
      w_plru_nxt = (w_plru_nxt & ~(PW'(1) << node)) | (PW'(nd) << node);
      node       = 2 * node + 1 + int'(d);
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_v[s]    <= '0;
        r_plru[s] <= '0;
      end
      r_miss_tag   <= '0;
      r_miss_set   <= '0;
      r_flush_pend <= 1'b0;
      r_flush_set  <= '0;
    end else begin
      if (w_miss_start) begin
        r_miss_tag <= w_tag;
        r_miss_set <= w_set;
      end
      // A flush seen while a fill is in flight is held until the fill lands.
      if (r_state == ST_REQ && flush) r_flush_pend <= 1'b1;
      else if (w_flush_start)         r_flush_pend <= 1'b0;

      if (w_flush_start) begin
        r_flush_set <= '0;
      end else if (r_state == ST_FLUSH) begin
        r_v[r_flush_set] <= '0;
        r_flush_set      <= r_flush_set + SET_W'(1);
      end

      if (w_fill)   r_v[r_miss_set][w_victim] <= 1'b1;
      if (w_upd_en) r_plru[w_upd_set]         <= w_plru_nxt;
    end
  end

  // Line data and tags are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[r_miss_set][w_victim] <= b_data;
      r_tag[r_miss_set][w_victim]  <= r_miss_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [63:0] r_hit_cnt;
  logic [63:0] r_miss_cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (ir_vld)       r_hit_cnt  <= r_hit_cnt + 64'd1;
      if (w_miss_start) r_miss_cnt <= r_miss_cnt + 64'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Purpose  : Self-checking bench for icache (default parameters). Stimulus
//            pushes expected bus addresses and instructions into queues; a
//            negedge monitor pops and compares whenever the cache presents a
//            hit or raises a bus request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache;

  logic          clk;
  logic          clr_n;
  logic [63:0]   pc;
  logic          pc_rd;
  logic [31:0]   ir;
  logic          ir_vld;
  logic          stall;
  logic          flush;
  logic [63:0]   b_addr;
  logic          b_rd;
  logic          b_dv;
  logic [1023:0] b_data;
`ifdef ICACHE_PERF_EN
  logic [63:0]   hit_cnt;
  logic [63:0]   miss_cnt;
`endif

  icache dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .pc     (pc),
    .pc_rd  (pc_rd),
    .ir     (ir),
    .ir_vld (ir_vld),
    .stall  (stall),
    .flush  (flush),
    .b_addr (b_addr),
    .b_rd   (b_rd),
    .b_dv   (b_dv),
    .b_data (b_data)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_ir   [$];
  logic [63:0] exp_addr [$];
  logic        prev_b_rd = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Test line contents: word k of a line built from seed.
  function automatic logic [31:0] word_of(input int seed, input int k);
    if (seed == 0 && k == 0) return 32'hDEADBEEF;
    return {seed[7:0], k[7:0], 8'h5A, 8'hC3 ^ k[7:0]};
  endfunction

  function automatic logic [1023:0] make_line(input int seed);
    logic [1023:0] l;
    l = '0;
    for (int k = 0; k < 32; k++) l[32*k +: 32] = word_of(seed, k);
    return l;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a hit or a new request.
  always @(negedge clk) begin
    if (clr_n) begin
      if (ir_vld) begin
        if (exp_ir.size() == 0) check("ir_unexpected_hit", {32'h0, ir}, 64'hFFFF_FFFF_FFFF_FFFF);
        else                    check("sb_ir", {32'h0, ir}, {32'h0, exp_ir.pop_front()});
      end else begin
        check("ir_zero_when_invalid", {32'h0, ir}, 64'h0);
      end
      if (b_rd && !prev_b_rd) begin
        if (exp_addr.size() == 0) check("b_rd_unexpected", b_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        else                      check("sb_b_addr", b_addr, exp_addr.pop_front());
      end
    end
    prev_b_rd = b_rd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Miss on addr, hold the request for 'waits' extra cycles, return line
  // 'seed', then expect the hit in the following cycle.
  task automatic do_miss(input logic [63:0] addr, input int seed, input int waits);
    int n;
    pc    = addr;
    pc_rd = 1'b1;
    exp_addr.push_back(addr & ~64'h7F);
    @(negedge clk);
    check("miss_stall", {63'h0, stall}, 64'h1);
    check("miss_no_b_rd_cycle0", {63'h0, b_rd}, 64'h0);
    tick();
    n = 0;
    while (!b_rd && n < 20) begin
      tick();
      n++;
    end
    check("b_rd_wait", {63'h0, b_rd}, 64'h1);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check("b_rd_hold", {63'h0, b_rd}, 64'h1);
      tick();
    end
    b_dv   = 1'b1;
    b_data = make_line(seed);
    exp_ir.push_back(word_of(seed, int'(addr[6:2])));
    tick();
    b_dv = 1'b0;
    @(negedge clk);
    check("b_rd_drop", {63'h0, b_rd}, 64'h0);
    check("fill_hit", {63'h0, ir_vld}, 64'h1);
    tick();
    pc_rd = 1'b0;
  endtask

  task automatic do_hit(input logic [63:0] addr, input int seed);
    pc    = addr;
    pc_rd = 1'b1;
    exp_ir.push_back(word_of(seed, int'(addr[6:2])));
    @(negedge clk);
    check("hit_vld", {63'h0, ir_vld}, 64'h1);
    check("hit_no_b_rd", {63'h0, b_rd}, 64'h0);
    tick();
    pc_rd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n  = 1'b0;
    pc     = 64'h1000;
    pc_rd  = 1'b1;
    flush  = 1'b0;
    b_dv   = 1'b0;
    b_data = '0;
    #3;
    // Outputs under reset
    check("rst_b_rd",   {63'h0, b_rd},   64'h0);
    check("rst_b_addr", b_addr,          64'h0);
    check("rst_ir_vld", {63'h0, ir_vld}, 64'h0);
    check("rst_ir",     {32'h0, ir},     64'h0);
    check("rst_stall",  {63'h0, stall},  64'h1);
    tick();
    clr_n = 1'b1;
    pc_rd = 1'b0;
    tick();

    // Cold miss: b_dv in cycle 3, hit in cycle 4 with word 0 = DEADBEEF
    do_miss(64'h1000, 0, 2);
`ifdef ICACHE_PERF_EN
    check("perf_miss_cnt", miss_cnt, 64'd1);
    check("perf_hit_cnt",  hit_cnt,  64'd1);
`endif

    // Word select within the filled line
    do_hit(64'h107C, 0);
    do_hit(64'h1040, 0);
    do_hit(64'h1003, 0);

    // Flush: 4 cycles with no hit, then 0x0 misses
    flush = 1'b1;
    pc_rd = 1'b0;
    tick();
    flush = 1'b0;
    pc    = 64'h1000;
    pc_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_ir_vld", {63'h0, ir_vld}, 64'h0);
      tick();
    end

    // PLRU: fill set 0 with four tags, touch 0x0 then 0x600; 0x200 is the
    // oldest branch and gets evicted by 0x800.
    do_miss(64'h0,   10, 0);
    do_miss(64'h200, 11, 0);
    do_miss(64'h400, 12, 1);
    do_miss(64'h600, 13, 0);
    do_hit(64'h0,   10);
    do_hit(64'h600, 13);
    do_miss(64'h800, 14, 0);
    do_hit(64'h0,   10);
    do_hit(64'h404, 12);
    do_hit(64'h600, 13);
    do_hit(64'h87C, 14);
    do_miss(64'h200, 11, 0);

    // Flush during REQ: fill completes, then the pending flush runs
    pc    = 64'h2000;
    pc_rd = 1'b1;
    exp_addr.push_back(64'h2000);
    @(negedge clk);
    check("fr_stall", {63'h0, stall}, 64'h1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("fr_b_rd", {63'h0, b_rd}, 64'h1);
    tick();
    flush  = 1'b0;
    b_dv   = 1'b1;
    b_data = make_line(20);
    tick();
    b_dv = 1'b0;
    exp_ir.push_back(word_of(20, 0));
    @(negedge clk);
    check("fr_b_rd_drop", {63'h0, b_rd},   64'h0);
    check("fr_fill_hit",  {63'h0, ir_vld}, 64'h1);
    tick();
    pc = 64'h400;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fr_flush_ir_vld", {63'h0, ir_vld}, 64'h0);
      tick();
    end
    do_miss(64'h400, 21, 0);

    // Reset mid-miss: b_rd drops at once, a late b_dv installs nothing
    pc    = 64'h3000;
    pc_rd = 1'b1;
    exp_addr.push_back(64'h3000);
    @(negedge clk);
    check("rm_stall", {63'h0, stall}, 64'h1);
    tick();
    @(negedge clk);
    check("rm_b_rd", {63'h0, b_rd}, 64'h1);
    tick();
    #1;
    clr_n = 1'b0;
    #1;
    check("rm_b_rd_async_drop", {63'h0, b_rd}, 64'h0);
    check("rm_b_addr_reset",    b_addr,        64'h0);
    tick();
    clr_n  = 1'b1;
    pc_rd  = 1'b0;
    b_dv   = 1'b1;
    b_data = make_line(30);
    tick();
    b_dv = 1'b0;
    do_miss(64'h3000, 31, 0);
`ifdef ICACHE_PERF_EN
    check("perf_miss_after_rst", miss_cnt, 64'd1);
`endif

    tick();
    check("sb_ir_left",   64'(exp_ir.size()),   64'h0);
    check("sb_addr_left", 64'(exp_addr.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
